dl_ctrl: RTL and testbench
==========================

DL_CTRL -- requirements
Module: dl_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: number of entries in the ROM write buffer; power of two, at least 2.
REQ-002 SHALL have parameter RST_HOLD, default 16: clk_sys cycles that core_reset is held after the ROM path drains.
REQ-003 SHALL have clk_sys, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have RESET, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ioctl_download, input, 1 bit: the HPS download is active.
REQ-006 SHALL have ioctl_index, input, 8 bits: download target index.
REQ-007 SHALL have ioctl_wr, input, 1 bit: one-cycle byte-write strobe.
REQ-008 SHALL have ioctl_addr, input, 25 bits: byte address.
REQ-009 SHALL have ioctl_dout, input, 8 bits: byte data.
REQ-010 SHALL have ioctl_wait, output, 1 bit: backpressure to the HPS.
REQ-011 SHALL have rom_addr, output, 16 bits: ROM write address (the FIFO head).
REQ-012 SHALL have rom_data, output, 8 bits: ROM write data (the FIFO head).
REQ-013 SHALL have rom_wr, output, 1 bit: ROM write request.
REQ-014 SHALL have rom_rdy, input, 1 bit: the ROM port accepts the write this cycle.
REQ-015 SHALL have mod, output, 8 bits: game variant byte.
REQ-016 SHALL have sw, output, 64 bits: DIP bank; byte n is sw[8n+7:8n].
REQ-017 SHALL have core_reset, output, 1 bit: registered reset to the game core.
REQ-018 SHALL have overflow, output, 1 bit: sticky flag for a dropped write.

Function
REQ-019 Index 0 ROM writes SHALL push {ioctl_addr[15:0], ioctl_dout} into the FIFO when all of these hold: ioctl_wr=1, ioctl_index=0, ioctl_addr[24:16]=0, and the FIFO is not full.
REQ-020 An index 0 write with a nonzero ioctl_addr[24:16] SHALL be discarded silently.
REQ-021 An index 0 write while the FIFO is full SHALL be dropped, SHALL set overflow, and SHALL NOT change FIFO contents.
REQ-022 ioctl_wait SHALL be combinational and SHALL be 1 whenever the count is at least FIFO_DEPTH-1, so one in-flight write still fits.
REQ-023 rom_wr SHALL be 1 exactly when the FIFO is non-empty; rom_addr and rom_data SHALL show the head entry and stay stable until it is popped.
REQ-024 The FIFO SHALL pop on a cycle with rom_wr=1 and rom_rdy=1; the next entry SHALL appear on the following cycle.
REQ-025 A push and a pop in the same cycle SHALL leave the count unchanged and SHALL preserve order; this is legal when the FIFO is full.
REQ-026 Read and write pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL range 0..FIFO_DEPTH.
REQ-027 Write latency from ioctl_wr to rom_wr SHALL be 1 cycle when the FIFO was empty.
REQ-028 Index 1 writes: on ioctl_wr=1 with ioctl_index=1, mod SHALL take ioctl_dout on the next edge, at any address; the last write wins.
REQ-029 Index 254 writes: on ioctl_wr=1 with ioctl_index=254 and ioctl_addr[24:3]=0, byte ioctl_addr[2:0] of sw SHALL take ioctl_dout; other addresses SHALL be ignored.
REQ-030 Writes with any other index SHALL be ignored.
REQ-031 The controller SHALL be a state machine with states IDLE, LOAD, DRAIN and HOLD.
REQ-032 From IDLE, the state SHALL move to LOAD when ioctl_download=1 and ioctl_index=0.
REQ-033 From LOAD, the state SHALL move to DRAIN when ioctl_download=0.
REQ-034 From DRAIN, the state SHALL move to HOLD when the FIFO is empty, and the hold counter SHALL clear on that transition.
REQ-035 HOLD SHALL count 0..RST_HOLD-1 and then move to IDLE.
REQ-036 From DRAIN or HOLD, ioctl_download=1 with ioctl_index=0 SHALL move the state to LOAD and clear the counter.
REQ-037 A download with a nonzero index SHALL NOT affect the state machine.
REQ-038 core_reset SHALL be a registered decode: 1 in LOAD, DRAIN and HOLD; 0 in IDLE.
REQ-039 Pushes SHALL be accepted in any state.

Reset
REQ-040 While RESET=1, all outputs SHALL be forced asynchronously to: FIFO empty, rom_wr=0, ioctl_wait=0, mod=0, sw=all ones (64'hFFFF_FFFF_FFFF_FFFF), overflow=0, core_reset=1, state=HOLD, counter=0.
REQ-041 After RESET falls, core_reset SHALL stay 1 for RST_HOLD cycles.
REQ-042 A reset in the middle of a download SHALL discard FIFO contents.

Verification
REQ-043 Release RESET with no download -> core_reset=1 for exactly 16 cycles then 0; sw=all ones; mod=0.
REQ-044 Download index 0 with 8 bytes, rom_rdy tied 1 -> 8 in-order rom_wr pulses at addresses 0..7, each 1 cycle after its ioctl_wr; core_reset falls 16 cycles after the last pop.
REQ-045 rom_rdy=0 while 4 writes arrive -> ioctl_wait rises after the 3rd write; the 4th is accepted; a forced 5th sets overflow and is not written; rom_rdy=1 then yields the 4 bytes in order.
REQ-046 Index 254 write at addr 2 with data 0x5A, plus one at addr 8 -> sw[23:16]=0x5A and all other bytes are 0xFF. Index 1 write with data 0x0B -> mod=0x0B and core_reset is unaffected.
REQ-047 Assert RESET mid-DRAIN with 2 entries queued -> rom_wr=0 immediately and core_reset=1; after release the queued data is never written.

Source files
------------

// File: rtl/dl_ctrl_if.sv
// Download/ROM-write bus for dl_ctrl: HPS ioctl side plus the ROM write port.
interface dl_ctrl_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_wr;
  logic        rom_rdy;

  // Drives the download and accepts ROM writes (HPS side / testbench).
  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, rom_rdy,
    input  ioctl_wait, rom_addr, rom_data, rom_wr
  );

  // The download controller itself.
  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, rom_rdy,
    output ioctl_wait, rom_addr, rom_data, rom_wr
  );
endinterface

// File: rtl/dl_ctrl.sv
// Download controller: buffers index-0 ROM bytes in a small FIFO towards the
// ROM write port, captures the variant byte (index 1) and DIP bank (index 254),
// and holds the game core in reset while a ROM load is in progress and for
// RST_HOLD cycles after the ROM path has drained.
module dl_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int RST_HOLD   = 16
) (
  input  logic        clk_sys,
  input  logic        RESET,
  dl_ctrl_if.slave    bus,
  output logic [7:0]  mod,
  output logic [63:0] sw,
  output logic        core_reset,
  output logic        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(RST_HOLD + 1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, HOLD} state_t;

  logic [15:0]   fifo_addr [FIFO_DEPTH];
  logic [7:0]    fifo_data [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;

  logic fifo_full;
  logic fifo_empty;
  logic rom_req;
  logic push;
  logic pop;
  logic drop;
  logic start_load;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] hold_cnt;
  logic [CW-1:0] hold_cnt_next;

  assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);

  // A ROM byte is only meaningful inside the 64 KiB window.
  assign rom_req = bus.ioctl_wr && (bus.ioctl_index == 8'd0) &&
                   (bus.ioctl_addr[24:16] == 9'd0);

  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign pop  = !fifo_empty && bus.rom_rdy;
  assign push = rom_req && (!fifo_full || pop);
  assign drop = rom_req && fifo_full && !pop;

  assign start_load = bus.ioctl_download && (bus.ioctl_index == 8'd0);

  // Wait asserts one entry early so the write already in flight still fits.
  assign bus.ioctl_wait = (count >= (AW+1)'(FIFO_DEPTH - 1));
  assign bus.rom_wr     = !fifo_empty;
  assign bus.rom_addr   = fifo_addr[rd_ptr];
  assign bus.rom_data   = fifo_data[rd_ptr];

  // Occupancy after this cycle's push/pop; also tells DRAIN when it is done.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + (AW+1)'(1);
      2'b01:   count_next = count - (AW+1)'(1);
      default: count_next = count;
    endcase
  end

  // FIFO storage; contents are don't-care until the pointers say otherwise.
  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.ioctl_addr[15:0];
      fifo_data[wr_ptr] <= bus.ioctl_dout;
    end
  end

  // FIFO pointers, occupancy and the sticky dropped-write flag.
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      if (drop) overflow <= 1'b1;
    end
  end

  // Variant byte and DIP bank captured from their download indices.
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      mod <= 8'h00;
      sw  <= 64'hFFFF_FFFF_FFFF_FFFF;
    end else if (bus.ioctl_wr) begin
      if (bus.ioctl_index == 8'd1)
        mod <= bus.ioctl_dout;
      if ((bus.ioctl_index == 8'd254) && (bus.ioctl_addr[24:3] == 22'd0))
        sw[{bus.ioctl_addr[2:0], 3'b000} +: 8] <= bus.ioctl_dout;
    end
  end

  // Load sequencing state, hold counter and the registered core reset.
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      state      <= HOLD;
      hold_cnt   <= '0;
      core_reset <= 1'b1;
    end else begin
      state      <= state_next;
      hold_cnt   <= hold_cnt_next;
      core_reset <= (state_next != IDLE);
    end
  end

  // Next state: a new index-0 download always restarts LOAD; DRAIN ends once
  // the last queued byte leaves; HOLD then keeps the core in reset a while.
  always_comb begin
    state_next    = state;
    hold_cnt_next = hold_cnt;
    case (state)
      IDLE: begin
        if (start_load) begin
          state_next    = LOAD;
          hold_cnt_next = '0;
        end
      end
      LOAD: begin
        if (!bus.ioctl_download)
          state_next = DRAIN;
      end
      DRAIN: begin
        if (start_load) begin
          state_next    = LOAD;
          hold_cnt_next = '0;
        end else if (count_next == '0) begin
          state_next    = HOLD;
          hold_cnt_next = '0;
        end
      end
      HOLD: begin
        if (start_load) begin
          state_next    = LOAD;
          hold_cnt_next = '0;
        end else if (hold_cnt == CW'(RST_HOLD - 1)) begin
          state_next = IDLE;
        end else begin
          hold_cnt_next = hold_cnt + CW'(1);
        end
      end
      default: begin
        state_next    = HOLD;
        hold_cnt_next = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_dl_ctrl.sv
// Self-checking bench for dl_ctrl: reset behaviour, a table of config/ROM
// vectors, hand-written load/backpressure/reset sequences, then a randomized
// run against a queue-based reference model.
module tb_dl_ctrl;

  localparam int DEPTH = 4;
  localparam int HOLDN = 16;

  logic        clk_sys;
  logic        reset;
  logic [7:0]  mod;
  logic [63:0] sw;
  logic        core_reset;
  logic        overflow;

  int checks_total;
  int checks_passed;

  dl_ctrl_if bus();

  dl_ctrl #(.FIFO_DEPTH(DEPTH), .RST_HOLD(HOLDN)) dut (
    .clk_sys    (clk_sys),
    .RESET      (reset),
    .bus        (bus),
    .mod        (mod),
    .sw         (sw),
    .core_reset (core_reset),
    .overflow   (overflow)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic        dl;
    logic [7:0]  idx;
    logic [24:0] addr;
    logic [7:0]  dout;
    logic [7:0]  exp_mod;
    logic [63:0] exp_sw;
    logic        exp_rom_wr;
  } vec_t;

  vec_t vecs[10];

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic applyStimulus(input logic dl, input logic wr, input logic [7:0] idx,
                               input logic [24:0] addr, input logic [7:0] dout,
                               input logic rdy);
    bus.ioctl_download = dl;
    bus.ioctl_wr       = wr;
    bus.ioctl_index    = idx;
    bus.ioctl_addr     = addr;
    bus.ioctl_dout     = dout;
    bus.rom_rdy        = rdy;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Wait for core_reset to drop, returning the number of clocks taken.
  task automatic waitCoreReset(output int n);
    n = 0;
    while (core_reset && n < 200) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    logic seen;
    logic [23:0] q[$];
    logic [23:0] head;
    logic [7:0]  m_mod;
    logic [63:0] m_sw;
    logic        m_ovf;
    logic        dl, wr, rdy, m_pop, m_push;
    logic [7:0]  idx, dout;
    logic [24:0] addr;
    int          r, a;

    checks_total  = 0;
    checks_passed = 0;
    reset = 1'b1;
    applyStimulus(0, 0, 8'd0, 25'd0, 8'd0, 1'b0);

    // ---------------- reset state and release ----------------
    tick(); tick(); tick();
    checkOutput("reset rom_wr", bus.rom_wr, 0);
    checkOutput("reset ioctl_wait", bus.ioctl_wait, 0);
    checkOutput("reset mod", mod, 0);
    checkOutput("reset sw", sw, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("reset overflow", overflow, 0);
    checkOutput("reset core_reset", core_reset, 1);
    reset = 1'b0;
    applyStimulus(0, 0, 8'd0, 25'd0, 8'd0, 1'b1);
    waitCoreReset(n);
    checkOutput("core_reset hold after release", n, HOLDN);
    checkOutput("sw after release", sw, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("mod after release", mod, 0);

    // ---------------- table-driven vectors ----------------
    vecs[0] = '{1'b0, 8'd254, 25'd2,         8'h5A, 8'h00, 64'hFFFF_FFFF_FF5A_FFFF, 1'b0};
    vecs[1] = '{1'b0, 8'd254, 25'd8,         8'h00, 8'h00, 64'hFFFF_FFFF_FF5A_FFFF, 1'b0};
    vecs[2] = '{1'b1, 8'd1,   25'h123,       8'h0B, 8'h0B, 64'hFFFF_FFFF_FF5A_FFFF, 1'b0};
    vecs[3] = '{1'b0, 8'd254, 25'd7,         8'h12, 8'h0B, 64'h12FF_FFFF_FF5A_FFFF, 1'b0};
    vecs[4] = '{1'b0, 8'd7,   25'd0,         8'h99, 8'h0B, 64'h12FF_FFFF_FF5A_FFFF, 1'b0};
    vecs[5] = '{1'b0, 8'd0,   25'h10000,     8'h77, 8'h0B, 64'h12FF_FFFF_FF5A_FFFF, 1'b0};
    vecs[6] = '{1'b0, 8'd0,   25'h42,        8'hC3, 8'h0B, 64'h12FF_FFFF_FF5A_FFFF, 1'b1};
    vecs[7] = '{1'b0, 8'd1,   25'h1FFFFFF,   8'h44, 8'h44, 64'h12FF_FFFF_FF5A_FFFF, 1'b0};
    vecs[8] = '{1'b1, 8'd254, 25'h1000000,   8'h00, 8'h44, 64'h12FF_FFFF_FF5A_FFFF, 1'b0};
    vecs[9] = '{1'b0, 8'd254, 25'd0,         8'hA5, 8'h44, 64'h12FF_FFFF_FF5A_FFA5, 1'b0};
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].dl, 1'b1, vecs[i].idx, vecs[i].addr, vecs[i].dout, 1'b1);
      tick();
      applyStimulus(0, 0, 8'd0, 25'd0, 8'd0, 1'b1);
      checkOutput($sformatf("vec%0d mod", i), mod, vecs[i].exp_mod);
      checkOutput($sformatf("vec%0d sw", i), sw, vecs[i].exp_sw);
      checkOutput($sformatf("vec%0d rom_wr", i), bus.rom_wr, vecs[i].exp_rom_wr);
      checkOutput($sformatf("vec%0d core_reset", i), core_reset, 0);
      if (vecs[i].exp_rom_wr)
        checkOutput($sformatf("vec%0d rom head", i), {bus.rom_addr, bus.rom_data},
                    {vecs[i].addr[15:0], vecs[i].dout});
    end

    // ---------------- 8-byte load with rom_rdy tied high ----------------
    applyStimulus(1, 0, 8'd0, 25'd0, 8'd0, 1'b1);
    tick();
    checkOutput("load core_reset", core_reset, 1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(i != 7, 1'b1, 8'd0, 25'(i), 8'hA0 + 8'(i), 1'b1);
      tick();
      checkOutput($sformatf("load%0d rom_wr", i), bus.rom_wr, 1);
      checkOutput($sformatf("load%0d rom head", i), {bus.rom_addr, bus.rom_data},
                  {16'(i), 8'hA0 + 8'(i)});
    end
    applyStimulus(0, 0, 8'd0, 25'd0, 8'd0, 1'b1);
    tick();
    checkOutput("load drained rom_wr", bus.rom_wr, 0);
    waitCoreReset(n);
    checkOutput("core_reset hold after last pop", n, HOLDN);

    // ---------------- backpressure and overflow ----------------
    applyStimulus(1, 0, 8'd0, 25'd0, 8'd0, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1'b1, 8'd0, 25'h100 + 25'(i), 8'h30 + 8'(i), 1'b0);
      tick();
      checkOutput($sformatf("bp%0d ioctl_wait", i), bus.ioctl_wait, (i >= 2));
      checkOutput($sformatf("bp%0d overflow", i), overflow, (i == 4));
      checkOutput($sformatf("bp%0d head stable", i), {bus.rom_addr, bus.rom_data},
                  {16'h0100, 8'h30});
    end
    applyStimulus(1, 0, 8'd0, 25'd0, 8'd0, 1'b1);
    for (int j = 0; j < 4; j++) begin
      checkOutput($sformatf("bp drain%0d rom_wr", j), bus.rom_wr, 1);
      checkOutput($sformatf("bp drain%0d head", j), {bus.rom_addr, bus.rom_data},
                  {16'h0100 + 16'(j), 8'h30 + 8'(j)});
      tick();
    end
    checkOutput("bp empty rom_wr", bus.rom_wr, 0);
    checkOutput("bp empty ioctl_wait", bus.ioctl_wait, 0);
    applyStimulus(0, 0, 8'd0, 25'd0, 8'd0, 1'b1);
    waitCoreReset(n);
    checkOutput("bp core_reset falls", n < 200, 1);

    // ---------------- reset in the middle of DRAIN ----------------
    applyStimulus(1, 0, 8'd0, 25'd0, 8'd0, 1'b0);
    tick();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 1'b1, 8'd0, 25'h200 + 25'(i), 8'h60 + 8'(i), 1'b0);
      tick();
    end
    applyStimulus(0, 0, 8'd0, 25'd0, 8'd0, 1'b0);
    tick();
    checkOutput("drain queued rom_wr", bus.rom_wr, 1);
    reset = 1'b1;
    #1;
    checkOutput("midreset rom_wr", bus.rom_wr, 0);
    checkOutput("midreset core_reset", core_reset, 1);
    checkOutput("midreset overflow", overflow, 0);
    tick();
    reset = 1'b0;
    applyStimulus(0, 0, 8'd0, 25'd0, 8'd0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.rom_wr) seen = 1'b1;
      tick();
    end
    checkOutput("midreset no stale writes", seen, 0);
    waitCoreReset(n);
    checkOutput("midreset core_reset falls", n < 200, 1);

    // ---------------- randomized run against the reference model ----------------
    q.delete();
    m_mod = 8'h00;
    m_sw  = 64'hFFFF_FFFF_FFFF_FFFF;
    m_ovf = 1'b0;
    for (int c = 0; c < 400; c++) begin
      checkOutput("rnd rom_wr", bus.rom_wr, (q.size() != 0));
      if (q.size() != 0) begin
        head = q[0];
        checkOutput("rnd rom head", {bus.rom_addr, bus.rom_data}, head);
      end
      checkOutput("rnd ioctl_wait", bus.ioctl_wait, (q.size() >= DEPTH - 1));
      checkOutput("rnd overflow", overflow, m_ovf);
      checkOutput("rnd mod", mod, m_mod);
      checkOutput("rnd sw", sw, m_sw);
      checkOutput("rnd core_reset", core_reset, 0);

      wr = ($urandom % 3) != 0;
      r  = $urandom % 8;
      if (r < 4)       idx = 8'd0;
      else if (r == 4) idx = 8'd1;
      else if (r == 5) idx = 8'd254;
      else             idx = 8'($urandom_range(2, 253));
      if (($urandom % 6) == 0) addr = 25'($urandom);
      else                     addr = 25'($urandom % 16);
      dout = 8'($urandom);
      rdy  = $urandom % 2;
      dl   = (idx != 8'd0) && (($urandom % 4) == 0);
      applyStimulus(dl, wr, idx, addr, dout, rdy);

      m_pop  = (q.size() != 0) && rdy;
      m_push = 1'b0;
      if (wr && idx == 8'd0 && addr[24:16] == 9'd0) begin
        if (q.size() == DEPTH && !m_pop) m_ovf = 1'b1;
        else                             m_push = 1'b1;
      end
      if (m_pop)  void'(q.pop_front());
      if (m_push) q.push_back({addr[15:0], dout});
      if (wr && idx == 8'd1) m_mod = dout;
      if (wr && idx == 8'd254 && addr[24:3] == 22'd0) begin
        a = int'(addr[2:0]);
        m_sw[a*8 +: 8] = dout;
      end
      tick();
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
